// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the forwarding / hazard controller: forward-mux
// select encoding, register-index width and the per-stage shadow record.
package hazard_forward_ctrl_pkg;

  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  // Operand-mux select encoding; 2'b11 is never produced.
  localparam logic [1:0] FWD_REG = 2'b00;  // register-file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM result

  // Destination info tracked for one pipeline stage.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
    logic              memread;
  } stage_info_t;

  localparam stage_info_t STAGE_EMPTY = '0;

  // True when the stage holds a live instruction that will write register idx.
  // Register 0 is hard-wired zero, so it never produces a result.
  function automatic logic writes_reg(input stage_info_t s,
                                      input logic [REG_AW-1:0] idx);
    return s.valid && s.regwrite && (s.dst != '0) && (s.dst == idx);
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_compare.sv
// Combinational forward-select for one source operand. The nearer stage
// (EX, whose result will sit in EX/MEM) wins over MEM (result in MEM/WB).
module fwd_compare
  import hazard_forward_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  stage_info_t       ex_info,
  input  stage_info_t       mem_info,
  output logic [1:0]        sel
);

  // Priority compare: EX producer first, then MEM producer, else register file.
  always_comb begin
    sel = FWD_REG;
    if (writes_reg(ex_info, src)) begin
      sel = FWD_MEM;
    end else if (writes_reg(mem_info, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding and hazard controller for the 5-stage pipeline.
// Tracks destination info of the instructions in EX, MEM and WB, registers
// the operand forward selects for the next EX cycle, and raises load-use
// stall/bubble and branch flush.
// Optional build macro HAZARD_STATS_EN adds saturating stall/flush counters.
module hazard_forward_ctrl #(
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic              bubble,
  output logic              flush
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  import hazard_forward_ctrl_pkg::*;

  localparam int STG_EX     = 0;
  localparam int STG_MEM    = 1;
  localparam int STG_WB     = 2;
  localparam int NUM_STAGES = 3;
  localparam int NUM_OPS    = 2;

  // Configuration sanity: the shadow record is sized by the package width.
  if (REG_AW != hazard_forward_ctrl_pkg::REG_AW) begin : g_bad_aw
    $error("hazard_forward_ctrl: REG_AW must match the package width");
  end
  if (NUM_REGS < 2 || NUM_REGS > (1 << REG_AW)) begin : g_bad_regs
    $error("hazard_forward_ctrl: NUM_REGS does not fit REG_AW");
  end

  stage_info_t       shadow_reg [NUM_STAGES];
  stage_info_t       id_info;
  stage_info_t       ex_info;
  logic              load_use;
  logic              hold_fwd;
  logic [REG_AW-1:0] src_idx    [NUM_OPS];
  logic [1:0]        fwd_sel    [NUM_OPS];
  logic [1:0]        fwd_out    [NUM_OPS];

  assign ex_info    = shadow_reg[STG_EX];
  assign src_idx[0] = id_rs;
  assign src_idx[1] = id_rt;

  // Pack the ID-stage decode into a shadow record.
  always_comb begin
    id_info          = STAGE_EMPTY;
    id_info.valid    = id_valid;
    id_info.dst      = id_dst;
    id_info.regwrite = id_regwrite;
    id_info.memread  = id_memread;
  end

  // Load-use detection and flush; a taken branch squashes the stall.
  always_comb begin
    load_use = id_valid && ex_info.memread &&
               (writes_reg(ex_info, id_rs) || writes_reg(ex_info, id_rt));
    stall    = load_use && !ex_branch_taken;
    bubble   = stall;
    flush    = ex_branch_taken;
  end

  // Any of stall/bubble/flush means the ID instruction does not enter EX.
  assign hold_fwd = stall || bubble || flush;

  // Shadow pipeline: ID enters EX (or an empty slot), older stages shift on.
  // WB is only tracked; the register file is write-before-read so it never forwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        shadow_reg[s] <= STAGE_EMPTY;
      end
    end else begin
      shadow_reg[STG_EX] <= (bubble || flush) ? STAGE_EMPTY : id_info;
      for (int s = STG_MEM; s <= STG_WB; s++) begin
        shadow_reg[s] <= shadow_reg[s-1];
      end
    end
  end

  // One compare + select register per EX operand (rs -> A, rt -> B).
  for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_operand
    logic [1:0] sel_reg;

    fwd_compare u_fwd_compare (
      .src      (src_idx[gi]),
      .ex_info  (shadow_reg[STG_EX]),
      .mem_info (shadow_reg[STG_MEM]),
      .sel      (fwd_sel[gi])
    );

    // Register the select so EX sees it with no path from the id_* inputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sel_reg <= FWD_REG;
      end else if (hold_fwd) begin
        sel_reg <= FWD_REG;
      end else begin
        sel_reg <= fwd_sel[gi];
      end
    end

    assign fwd_out[gi] = sel_reg;
  end

  assign forward_a = fwd_out[0];
  assign forward_b = fwd_out[1];

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  // Saturating event counters, one count per asserted cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (flush && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed vector table,
// async-reset sequence, and randomized traffic against an in-flight
// instruction model. Honors HAZARD_STATS_EN when defined.
module tb_hazard_forward_ctrl;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic [AW-1:0] id_dst;
  logic          id_regwrite;
  logic          id_memread;
  logic          ex_branch_taken;
  logic [1:0]    forward_a;
  logic [1:0]    forward_b;
  logic          stall;
  logic          bubble;
  logic          flush;
`ifdef HAZARD_STATS_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.REG_AW(AW), .NUM_REGS(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_dst          (id_dst),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .ex_branch_taken (ex_branch_taken),
    .forward_a       (forward_a),
    .forward_b       (forward_b),
    .stall           (stall),
    .bubble          (bubble),
    .flush           (flush)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  // ---------------- reference model ----------------
  // In-flight instructions, youngest first: [0] in EX, [1] in MEM, [2] in WB.
  typedef struct {
    logic          v;
    logic [AW-1:0] dst;
    logic          rw;
    logic          mr;
  } ins_t;

  ins_t        flight[$];
  logic [1:0]  m_fa;
  logic [1:0]  m_fb;
  logic [31:0] m_scnt;
  logic [31:0] m_fcnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic void model_reset();
    flight.delete();
    m_fa   = 2'b00;
    m_fb   = 2'b00;
    m_scnt = '0;
    m_fcnt = '0;
  endfunction

  // Nearest older instruction that writes idx: one ahead -> 10, two ahead -> 01.
  function automatic logic [1:0] producer(input logic [AW-1:0] idx);
    for (int age = 0; age < 2 && age < flight.size(); age++) begin
      if (flight[age].v && flight[age].rw && flight[age].dst != 0 && flight[age].dst == idx)
        return (age == 0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One pipeline cycle: drive ID inputs, check at negedge, advance model.
  task automatic step(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                      input logic [AW-1:0] dst, input logic rw, input logic mr,
                      input logic br, input string tag,
                      output logic o_stall, output logic o_flush,
                      output logic [1:0] o_fa, output logic [1:0] o_fb);
    logic exp_stall;
    ins_t nx;
    id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst;
    id_regwrite = rw; id_memread = mr; ex_branch_taken = br;
    @(negedge clk);
    exp_stall = 1'b0;
    if (flight.size() > 0)
      if (v && flight[0].v && flight[0].mr && flight[0].rw && flight[0].dst != 0 &&
          (flight[0].dst == rs || flight[0].dst == rt))
        exp_stall = !br;
    o_stall = stall; o_flush = flush; o_fa = forward_a; o_fb = forward_b;
    check({tag, " stall"},     {31'd0, stall},     {31'd0, exp_stall});
    check({tag, " bubble"},    {31'd0, bubble},    {31'd0, exp_stall});
    check({tag, " flush"},     {31'd0, flush},     {31'd0, br});
    check({tag, " forward_a"}, {30'd0, forward_a}, {30'd0, m_fa});
    check({tag, " forward_b"}, {30'd0, forward_b}, {30'd0, m_fb});
`ifdef HAZARD_STATS_EN
    check({tag, " stall_cnt"}, stall_cnt, m_scnt);
    check({tag, " flush_cnt"}, flush_cnt, m_fcnt);
`endif
    if (exp_stall || br) begin
      m_fa = 2'b00; m_fb = 2'b00;
    end else begin
      m_fa = producer(rs); m_fb = producer(rt);
    end
    if (exp_stall || br) nx = '{1'b0, '0, 1'b0, 1'b0};
    else                 nx = '{v, dst, rw, mr};
    flight.push_front(nx);
    if (flight.size() > 3) void'(flight.pop_back());
    if (exp_stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
    if (br && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    id_valid = 0; id_rs = 0; id_rt = 0; id_dst = 0;
    id_regwrite = 0; id_memread = 0; ex_branch_taken = 0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check("reset forward_a", {30'd0, forward_a}, 32'd0);
    check("reset forward_b", {30'd0, forward_b}, 32'd0);
    check("reset stall",     {31'd0, stall},     32'd0);
    check("reset bubble",    {31'd0, bubble},    32'd0);
    check("reset flush",     {31'd0, flush},     32'd0);
`ifdef HAZARD_STATS_EN
    check("reset stall_cnt", stall_cnt, 32'd0);
    check("reset flush_cnt", flush_cnt, 32'd0);
`endif
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          v;
    logic [AW-1:0] rs, rt, dst;
    logic          rw, mr, br;
    logic          e_stall, e_flush;
    logic [1:0]    e_fa, e_fb;
  } vec_t;

  vec_t tbl [28];

  function automatic vec_t mk(input int v, input int rs, input int rt, input int dst,
                              input int rw, input int mr, input int br,
                              input int es, input int ef, input int fa, input int fb);
    vec_t r;
    r.v = v[0]; r.rs = rs[AW-1:0]; r.rt = rt[AW-1:0]; r.dst = dst[AW-1:0];
    r.rw = rw[0]; r.mr = mr[0]; r.br = br[0];
    r.e_stall = es[0]; r.e_flush = ef[0]; r.e_fa = fa[1:0]; r.e_fb = fb[1:0];
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       s_st, s_fl;
    logic [1:0] s_fa, s_fb;

    //            v rs rt dst rw mr br | stall flush fa fb
    tbl[0]  = mk(1, 1, 2,  3, 1, 0, 0,   0, 0, 0, 0);  // add $3
    tbl[1]  = mk(1, 3, 4,  6, 1, 0, 0,   0, 0, 0, 0);  // sub uses $3 (rs)
    tbl[2]  = mk(0, 0, 0,  0, 0, 0, 0,   0, 0, 2, 0);  // sub in EX: A=10
    tbl[3]  = mk(1, 1, 2,  3, 1, 0, 0,   0, 0, 0, 0);  // add $3
    tbl[4]  = mk(0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0);  // nop
    tbl[5]  = mk(1, 7, 3,  8, 1, 0, 0,   0, 0, 0, 0);  // or uses $3 (rt)
    tbl[6]  = mk(0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 1);  // or in EX: B=01
    tbl[7]  = mk(1, 1, 2,  3, 1, 0, 0,   0, 0, 0, 0);  // add $3
    tbl[8]  = mk(1, 1, 2,  3, 1, 0, 0,   0, 0, 0, 0);  // add $3
    tbl[9]  = mk(1, 3, 9, 10, 1, 0, 0,   0, 0, 0, 0);  // use $3
    tbl[10] = mk(0, 0, 0,  0, 0, 0, 0,   0, 0, 2, 0);  // nearer wins: 10
    tbl[11] = mk(1, 1, 0,  5, 1, 1, 0,   0, 0, 0, 0);  // lw $5
    tbl[12] = mk(1, 5, 2, 11, 1, 0, 0,   1, 0, 0, 0);  // and $5: stall
    tbl[13] = mk(1, 5, 2, 11, 1, 0, 0,   0, 0, 0, 0);  // re-evaluated: no stall
    tbl[14] = mk(0, 0, 0,  0, 0, 0, 0,   0, 0, 1, 0);  // and in EX: A=01
    tbl[15] = mk(1, 1, 2,  0, 1, 1, 0,   0, 0, 0, 0);  // lw $0
    tbl[16] = mk(1, 0, 0, 12, 1, 0, 0,   0, 0, 0, 0);  // reads $0: no stall
    tbl[17] = mk(0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0);  // no forward of $0
    tbl[18] = mk(1, 1, 2,  7, 1, 1, 0,   0, 0, 0, 0);  // lw $7
    tbl[19] = mk(1, 7, 7, 13, 1, 0, 1,   0, 1, 0, 0);  // hazard + branch: flush wins
    tbl[20] = mk(1, 7, 0, 14, 1, 0, 0,   0, 0, 0, 0);  // EX cleared: no stall
    tbl[21] = mk(0, 0, 0,  0, 0, 0, 0,   0, 0, 1, 0);  // lw now in MEM -> 01
    tbl[22] = mk(0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0);
    tbl[23] = mk(1, 1, 2, 20, 1, 0, 0,   0, 0, 0, 0);  // add $20
    tbl[24] = mk(0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0);
    tbl[25] = mk(0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0);
    tbl[26] = mk(1, 20, 0, 21, 1, 0, 0,  0, 0, 0, 0);  // writer now in WB
    tbl[27] = mk(0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0);  // WB never forwards

    do_reset();

    for (int i = 0; i < 28; i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      step(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].dst, tbl[i].rw, tbl[i].mr, tbl[i].br,
           tag, s_st, s_fl, s_fa, s_fb);
      check({tag, " tbl_stall"}, {31'd0, s_st}, {31'd0, tbl[i].e_stall});
      check({tag, " tbl_flush"}, {31'd0, s_fl}, {31'd0, tbl[i].e_flush});
      check({tag, " tbl_fa"},    {30'd0, s_fa}, {30'd0, tbl[i].e_fa});
      check({tag, " tbl_fb"},    {30'd0, s_fb}, {30'd0, tbl[i].e_fb});
    end

    // Async reset in the middle of a pending load-use stall.
    step(1, 1, 2, 9, 1, 1, 0, "arst_lw", s_st, s_fl, s_fa, s_fb);
    id_valid = 1; id_rs = 9; id_rt = 0; id_dst = 10;
    id_regwrite = 1; id_memread = 0; ex_branch_taken = 0;
    #2;
    check("arst stall_before", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst stall_during",  {31'd0, stall},     32'd0);
    check("arst bubble_during", {31'd0, bubble},    32'd0);
    check("arst fa_during",     {30'd0, forward_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 9, 0, 10, 1, 0, 0, "arst_after", s_st, s_fl, s_fa, s_fb);
    check("arst no_stall_after", {31'd0, s_st}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, "arst_nop", s_st, s_fl, s_fa, s_fb);

    // Randomized traffic on a small register set to provoke hazards.
    for (int c = 0; c < 400; c++) begin
      logic          v, rw, mr, br;
      logic [AW-1:0] rs, rt, dst;
      v   = ($urandom_range(0, 3) != 0);
      rs  = AW'($urandom_range(0, 3));
      rt  = AW'($urandom_range(0, 3));
      dst = AW'($urandom_range(0, 3));
      rw  = ($urandom_range(0, 3) != 0);
      mr  = rw && ($urandom_range(0, 2) == 0);
      br  = ($urandom_range(0, 9) == 0);
      step(v, rs, rt, dst, rw, mr, br, $sformatf("rnd%0d", c), s_st, s_fl, s_fa, s_fb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage pipelined CPU.
- Keeps its own shadow copy of destination-register info for the EX, MEM and WB stages.
- Drives the 2-bit Forward selects of the two EX-stage operand 3:1 muxes, with registered outputs.
- Detects load-use hazards and branch flushes, and generates the pipeline stall, bubble and flush controls.

Parameters:
- REG_AW, 5, register-index width.
- NUM_REGS, 32, register count. Index 0 is hard-wired zero and is never forwarded.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_AW  source register A of the ID instruction.
- id_rt  in  REG_AW  source register B of the ID instruction.
- id_dst  in  REG_AW  decoded destination of the ID instruction.
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  1  ID instruction is a load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- forward_a  out  2  select for the operand-A mux in EX.
- forward_b  out  2  select for the operand-B mux in EX.
- stall  out  1  hold PC and IF/ID this cycle.
- bubble  out  1  load zero/NOP into ID/EX at the next edge.
- flush  out  1  zero IF/ID and ID/EX at the next edge.

Behaviour:
- Forward encoding, shared with the mux:
  - 00 = register-file value.
  - 01 = MEM/WB result.
  - 10 = EX/MEM result.
  - 11 is never driven.
- Shadow state: per stage {valid, dst, regwrite, memread} for EX, MEM and WB. All cleared on reset.
- Each clock edge:
  - MEM moves to WB and EX moves to MEM.
  - EX is loaded from the ID inputs, or cleared when bubble or flush is asserted.
- Registered forwarding, computed in ID for the next EX cycle:
  - If EX.regwrite && EX.valid && EX.dst != 0 && EX.dst == id_rs, then next forward_a = 10.
  - Else if the same test passes against MEM, then next forward_a = 01.
  - Else next forward_a = 00.
  - forward_b uses the same rules with id_rt.
  - On stall, bubble or flush, the next value is 00.
  - The nearer stage (EX/MEM) always has priority over MEM/WB.
- Register file is write-before-read: no forwarding from an instruction retiring in WB to ID.
- Load-use stall, combinational from inputs and EX shadow state:
  - stall = id_valid && EX.valid && EX.memread && EX.regwrite && EX.dst != 0 && (EX.dst == id_rs || EX.dst == id_rt).
  - bubble = stall.
  - The stall lasts exactly one cycle. After the bubble the load is in MEM, so the re-evaluated instruction forwards 01.
- Flush:
  - flush = ex_branch_taken.
  - Flush overrides stall: when ex_branch_taken = 1, stall = 0 and bubble = 0. The EX shadow entry is cleared.
- Outputs at reset: forward_a = 00, forward_b = 00, stall = 0, bubble = 0, flush = 0.
- Reset mid-operation asynchronously clears all shadow stages. No pending stall survives reset.
- No combinational path from id_* to forward_a or forward_b.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- With the macro defined:
  - Adds outputs stall_cnt (32 bits) and flush_cnt (32 bits).
  - Each counter increments on every cycle its signal is asserted, and saturates at 32'hFFFFFFFF.
  - Both counters are cleared by rst_n.
- Without the macro: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/header holds:
  - the FWD_REG = 2'b00, FWD_WB = 2'b01 and FWD_MEM = 2'b10 constants;
  - REG_AW;
  - the stage-info struct/field layout {valid, dst, regwrite, memread}.
- One sub-module: fwd_compare. It is combinational, takes one source index plus the EX and MEM info, and returns a 2-bit select. It is instantiated twice, for rs and rt.

Test Plan:
- Back-to-back ALU ops: add $3 then sub uses $3 as rs → the cycle sub is in EX has forward_a = 10, forward_b = 00, stall = 0.
- Gap of one instruction: add $3, nop, or uses $3 as rt → forward_b = 01 in EX.
- Double hazard: add $3, add $3, use $3 → forward_a = 10 (MEM priority over WB).
- Load-use: lw $5 then and uses $5 → stall = 1 and bubble = 1 for exactly 1 cycle, then forward = 01 for and in EX.
- Register zero: writer dst = 0, reader rs = 0 → forward_a = 00 and no stall, even after a load.
- Branch taken during load-use: ex_branch_taken = 1 while the stall condition holds → flush = 1, stall = 0, EX shadow cleared. With HAZARD_STATS_EN defined, flush_cnt goes 0 → 1 and stall_cnt is unchanged.
